// File: rtl/board_ctrl_grid_if.sv
//------------------------------------------------------------------------------
// board_ctrl_grid_if : pixel/game signal bundle between board_ctrl_grid and its
// environment (VGA timing, mine generator, buttons, colour sink).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface board_ctrl_grid_if #(
    parameter int GRID_W = 8,
    parameter int GRID_H = 8
);
    localparam int N  = GRID_W * GRID_H;
    localparam int CW = $clog2(N + 1);

    logic            active_pixels;
    logic [9:0]      x;
    logic [9:0]      y;
    logic [3:0]      keys;
    logic            flag_sw;
    logic            reveal_sw;
    logic            new_game;
    logic [N-1:0]    mine_map;
    logic [4*N-1:0]  adj;
    logic [23:0]     color_out;
    logic [CW-1:0]   reveal_count;
    logic [CW-1:0]   flag_count;
    logic            busy;
    logic            lost;
    logic            won;

    modport master (
        output active_pixels, x, y, keys, flag_sw, reveal_sw, new_game, mine_map, adj,
        input  color_out, reveal_count, flag_count, busy, lost, won
    );

    modport slave (
        input  active_pixels, x, y, keys, flag_sw, reveal_sw, new_game, mine_map, adj,
        output color_out, reveal_count, flag_count, busy, lost, won
    );
endinterface

`default_nettype wire

// File: rtl/board_ctrl_grid.sv
//------------------------------------------------------------------------------
// board_ctrl_grid : minesweeper board state, game FSM and per-pixel shader.
// Optional zero-tile flood fill built when BOARD_FLOOD_FILL_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module board_ctrl_grid #(
    parameter int GRID_W     = 8,
    parameter int GRID_H     = 8,
    parameter int TILE_SIZE  = 60,
    parameter int BORDER     = 4,
    parameter int X_OFFSET   = 80,
    parameter int Y_OFFSET   = 0,
    parameter int MINE_COUNT = 10
) (
    input  wire              clk,
    input  wire              rst,
    board_ctrl_grid_if.slave bus
);
    localparam int N   = GRID_W * GRID_H;
    localparam int CW  = $clog2(N + 1);
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int CXW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int CYW = (GRID_H > 1) ? $clog2(GRID_H) : 1;

    localparam logic [CW-1:0] TARGET = CW'(N - MINE_COUNT);
    localparam logic [10:0]   XO     = 11'(X_OFFSET);
    localparam logic [10:0]   YO     = 11'(Y_OFFSET);
    localparam logic [9:0]    GPW    = 10'(GRID_W * TILE_SIZE);
    localparam logic [9:0]    GPH    = 10'(GRID_H * TILE_SIZE);
    localparam logic [9:0]    TS     = 10'(TILE_SIZE);
    localparam logic [9:0]    BD     = 10'(BORDER);
    localparam logic [9:0]    TSB    = 10'(TILE_SIZE - BORDER);

    typedef enum logic [1:0] {S_PLAY, S_SWEEP, S_LOST, S_WON} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [N-1:0]    r_revealed;
    logic [N-1:0]    r_flagged;
    logic [CW-1:0]   r_reveal_count;
    logic [CW-1:0]   r_flag_count;
    logic [CXW-1:0]  r_cur_col;
    logic [CYW-1:0]  r_cur_row;
    logic [3:0]      r_key_prev;
    logic            r_flag_prev;
    logic            r_reveal_prev;

    logic [3:0]      w_press;
    logic [3:0]      w_key_edge;
    logic            w_flag_edge;
    logic            w_reveal_edge;
    logic [IW-1:0]   w_cur_idx;
    logic            w_do_reveal;
    logic            w_do_flag;
    logic [3:0]      w_adj [N];
    logic [N-1:0]    w_nb_mask;
    logic [3:0]      w_nb_cnt;
    logic            w_sweep_done;

    for (genvar t = 0; t < N; t++) begin : g_adj
        assign w_adj[t] = bus.adj[4*t +: 4];
    end

    // Keys are active-low; work with pressed-high levels from here on.
    assign w_press       = ~bus.keys;
    assign w_key_edge    = w_press & ~r_key_prev;
    assign w_flag_edge   = bus.flag_sw & ~r_flag_prev;
    assign w_reveal_edge = bus.reveal_sw & ~r_reveal_prev;
    assign w_cur_idx     = IW'(int'(r_cur_row) * GRID_W + int'(r_cur_col));

`ifdef BOARD_FLOOD_FILL_EN
    localparam bit FLOOD = 1'b1;

    logic [IW-1:0] r_idx;
    logic          r_changed;
    logic [IW-1:0] w_nb;
    int            w_sr;
    int            w_sc;

    always_comb begin
        w_nb_mask = '0;
        w_nb_cnt  = '0;
        w_nb      = '0;
        w_sr      = int'(r_idx) / GRID_W;
        w_sc      = int'(r_idx) % GRID_W;
        if (r_state == S_SWEEP && r_revealed[r_idx] && !bus.mine_map[r_idx]
                && w_adj[r_idx] == 4'd0) begin
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    if ((dr != 0 || dc != 0) && w_sr + dr >= 0 && w_sr + dr < GRID_H
                            && w_sc + dc >= 0 && w_sc + dc < GRID_W) begin
                        w_nb = IW'((w_sr + dr) * GRID_W + w_sc + dc);
                        if (!r_revealed[w_nb] && !r_flagged[w_nb]) begin
                            w_nb_mask[w_nb] = 1'b1;
                            w_nb_cnt        = w_nb_cnt + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // A pass that revealed nothing (including its last tile) ends the sweep.
    assign w_sweep_done = (r_idx == IW'(N - 1)) && !r_changed && (w_nb_cnt == 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx     <= '0;
            r_changed <= 1'b0;
        end else if (bus.new_game || (r_state == S_PLAY && w_state_next == S_SWEEP)) begin
            r_idx     <= '0;
            r_changed <= 1'b0;
        end else if (r_state == S_SWEEP) begin
            if (r_idx == IW'(N - 1)) begin
                r_idx     <= '0;
                r_changed <= 1'b0;
            end else begin
                r_idx     <= r_idx + IW'(1);
                r_changed <= r_changed | (w_nb_cnt != 4'd0);
            end
        end
    end

    assign bus.busy = (r_state == S_SWEEP);
`else
    localparam bit FLOOD = 1'b0;

    assign w_nb_mask    = '0;
    assign w_nb_cnt     = '0;
    assign w_sweep_done = 1'b1;
    assign bus.busy     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_PLAY;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_do_reveal  = 1'b0;
        w_do_flag    = 1'b0;
        if (bus.new_game) begin
            w_state_next = S_PLAY;
        end else begin
            case (r_state)
                S_PLAY: begin
                    if (r_reveal_count == TARGET) begin
                        w_state_next = S_WON;
                    end else if (w_reveal_edge) begin
                        if (!r_revealed[w_cur_idx] && !r_flagged[w_cur_idx]) begin
                            w_do_reveal = 1'b1;
                            if (bus.mine_map[w_cur_idx])
                                w_state_next = S_LOST;
                            else if (FLOOD && w_adj[w_cur_idx] == 4'd0)
                                w_state_next = S_SWEEP;
                            else if (r_reveal_count + CW'(1) == TARGET)
                                w_state_next = S_WON;
                        end
                    end else if (w_flag_edge && !r_revealed[w_cur_idx]) begin
                        w_do_flag = 1'b1;
                    end
                end
                S_SWEEP: if (w_sweep_done) w_state_next = S_PLAY;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_revealed     <= '0;
            r_flagged      <= '0;
            r_reveal_count <= '0;
            r_flag_count   <= '0;
            r_cur_col      <= '0;
            r_cur_row      <= '0;
            r_key_prev     <= '0;
            r_flag_prev    <= 1'b0;
            r_reveal_prev  <= 1'b0;
        end else begin
            r_key_prev    <= w_press;
            r_flag_prev   <= bus.flag_sw;
            r_reveal_prev <= bus.reveal_sw;
            if (bus.new_game) begin
                r_revealed     <= '0;
                r_flagged      <= '0;
                r_reveal_count <= '0;
                r_flag_count   <= '0;
                r_cur_col      <= '0;
                r_cur_row      <= '0;
            end else begin
                // Opposite keys on one axis cancel; moves saturate at the edges.
                if (w_key_edge[0] && !w_key_edge[3] && r_cur_col != CXW'(GRID_W - 1))
                    r_cur_col <= r_cur_col + CXW'(1);
                else if (w_key_edge[3] && !w_key_edge[0] && r_cur_col != '0)
                    r_cur_col <= r_cur_col - CXW'(1);
                if (w_key_edge[1] && !w_key_edge[2] && r_cur_row != CYW'(GRID_H - 1))
                    r_cur_row <= r_cur_row + CYW'(1);
                else if (w_key_edge[2] && !w_key_edge[1] && r_cur_row != '0)
                    r_cur_row <= r_cur_row - CYW'(1);

                if (w_do_reveal) begin
                    r_revealed[w_cur_idx] <= 1'b1;
                    r_reveal_count        <= r_reveal_count + CW'(1);
                end else if (w_do_flag) begin
                    r_flagged[w_cur_idx] <= ~r_flagged[w_cur_idx];
                    r_flag_count <= r_flagged[w_cur_idx] ? r_flag_count - CW'(1)
                                                         : r_flag_count + CW'(1);
                end else if (r_state == S_SWEEP) begin
                    r_revealed     <= r_revealed | w_nb_mask;
                    r_reveal_count <= r_reveal_count + CW'(w_nb_cnt);
                end
            end
        end
    end

    function automatic logic [23:0] tile_color(input logic [3:0] n);
        case (n)
            4'd1:    tile_color = 24'h0000FF;
            4'd2:    tile_color = 24'h008000;
            4'd3:    tile_color = 24'hE00000;
            4'd4:    tile_color = 24'h000080;
            4'd5:    tile_color = 24'h800000;
            4'd6:    tile_color = 24'h008080;
            4'd7:    tile_color = 24'h000000;
            default: tile_color = 24'h808080;
        endcase
    endfunction

    // Pixel shader: the 11-bit subtraction's top bit flags pixels left/above the grid.
    logic [10:0]    w_rx_full;
    logic [10:0]    w_ry_full;
    logic [9:0]     w_rx;
    logic [9:0]     w_ry;
    logic [9:0]     w_px;
    logic [9:0]     w_py;
    logic [CXW-1:0] w_pcol;
    logic [CYW-1:0] w_prow;
    logic [IW-1:0]  w_pix_idx;
    logic           w_in_grid;
    logic           w_border;
    logic           w_on_cursor;

    assign w_rx_full   = {1'b0, bus.x} - XO;
    assign w_ry_full   = {1'b0, bus.y} - YO;
    assign w_rx        = w_rx_full[9:0];
    assign w_ry        = w_ry_full[9:0];
    assign w_in_grid   = !w_rx_full[10] && !w_ry_full[10] && (w_rx < GPW) && (w_ry < GPH);
    assign w_pcol      = CXW'(w_rx / TS);
    assign w_prow      = CYW'(w_ry / TS);
    assign w_px        = w_rx % TS;
    assign w_py        = w_ry % TS;
    assign w_pix_idx   = IW'(int'(w_prow) * GRID_W + int'(w_pcol));
    assign w_border    = (w_px < BD) || (w_px >= TSB) || (w_py < BD) || (w_py >= TSB);
    assign w_on_cursor = (w_pcol == r_cur_col) && (w_prow == r_cur_row);

    always_comb begin
        bus.color_out = 24'h000000;
        if (!bus.active_pixels || !w_in_grid)
            bus.color_out = 24'h000000;
        else if (w_on_cursor && w_border)
            bus.color_out = 24'hFFFF00;
        else if (!r_revealed[w_pix_idx] && r_flagged[w_pix_idx])
            bus.color_out = 24'hFF00FF;
        else if (!r_revealed[w_pix_idx] && bus.mine_map[w_pix_idx] && r_state == S_LOST)
            bus.color_out = 24'hFF0000;
        else if (!r_revealed[w_pix_idx])
            bus.color_out = (w_pcol[0] ^ w_prow[0]) ? 24'h5E8F54 : 24'h8CC783;
        else if (bus.mine_map[w_pix_idx])
            bus.color_out = 24'hFF0000;
        else if (w_adj[w_pix_idx] != 4'd0)
            bus.color_out = tile_color(w_adj[w_pix_idx]);
        else
            bus.color_out = 24'hFFFFFF;
    end

    assign bus.reveal_count = r_reveal_count;
    assign bus.flag_count   = r_flag_count;
    assign bus.lost         = (r_state == S_LOST);
    assign bus.won          = (r_state == S_WON);

endmodule

`default_nettype wire

// File: tb/tb_board_ctrl_grid.sv
//------------------------------------------------------------------------------
// tb_board_ctrl_grid : directed self-checking bench for board_ctrl_grid (8x8).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_board_ctrl_grid;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    board_ctrl_grid_if #(.GRID_W(8), .GRID_H(8)) bus ();

    board_ctrl_grid #(
        .GRID_W(8), .GRID_H(8), .TILE_SIZE(60), .BORDER(4),
        .X_OFFSET(80), .Y_OFFSET(0), .MINE_COUNT(10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int cur_r    = 0;
    int cur_c    = 0;
    int timeouts = 0;
    logic [23:0] col;
    logic [63:0] mines;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] m);
        bus.keys = ~m;
        tick();
        bus.keys = 4'hF;
        tick();
    endtask

    task automatic goto(input int r, input int c);
        while (cur_c < c) begin press(4'b0001); cur_c++; end
        while (cur_c > c) begin press(4'b1000); cur_c--; end
        while (cur_r < r) begin press(4'b0010); cur_r++; end
        while (cur_r > r) begin press(4'b0100); cur_r--; end
    endtask

    task automatic pulse_flag();
        bus.flag_sw = 1'b1; tick();
        bus.flag_sw = 1'b0; tick();
    endtask

    task automatic pulse_reveal();
        bus.reveal_sw = 1'b1; tick();
        bus.reveal_sw = 1'b0; tick();
    endtask

    task automatic pulse_new_game();
        bus.new_game = 1'b1; tick();
        bus.new_game = 1'b0; tick();
        cur_r = 0;
        cur_c = 0;
    endtask

    task automatic pixel(input int px, input int py, output logic [23:0] c);
        bus.x = 10'(px);
        bus.y = 10'(py);
        #1;
        c = bus.color_out;
    endtask

    task automatic tile_px(input int r, input int c, output logic [23:0] cl);
        pixel(80 + c * 60 + 30, r * 60 + 30, cl);
    endtask

    function automatic logic [255:0] build_adj(input logic [63:0] m);
        logic [255:0] a;
        int n;
        a = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 &&
                            c + dc >= 0 && c + dc < 8 && m[(r + dr) * 8 + c + dc])
                            n++;
                a[4 * (r * 8 + c) +: 4] = 4'(n);
            end
        end
        return a;
    endfunction

    initial begin
        int n;
        // Mines fill row 5 plus the two bottom corners: rows 0-3 are an all-zero region.
        mines = 64'h0;
        for (int c = 0; c < 8; c++) mines[40 + c] = 1'b1;
        mines[56] = 1'b1;
        mines[63] = 1'b1;

        bus.active_pixels = 1'b1;
        bus.x = '0; bus.y = '0;
        bus.keys = 4'hF;
        bus.flag_sw = 1'b0; bus.reveal_sw = 1'b0; bus.new_game = 1'b0;
        bus.mine_map = mines;
        bus.adj = build_adj(mines);

        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Reset state and basic shading
        check("rst_reveal_count", bus.reveal_count, 0);
        check("rst_flag_count", bus.flag_count, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_lost", bus.lost, 0);
        check("rst_won", bus.won, 0);
        pixel(80, 0, col);   check("cursor_at_origin", col, 24'hFFFF00);
        tile_px(0, 0, col);  check("checker_even", col, 24'h8CC783);
        tile_px(0, 1, col);  check("checker_odd", col, 24'h5E8F54);
        pixel(10, 30, col);  check("outside_grid", col, 24'h000000);
        bus.active_pixels = 1'b0;
        tile_px(0, 0, col);  check("blanking", col, 24'h000000);
        bus.active_pixels = 1'b1;

        // Cursor: opposite keys cancel, right saturates at column 7
        press(4'b1001);
        pixel(80, 0, col);   check("cancel_stays", col, 24'hFFFF00);
        pixel(140, 0, col);  check("cancel_no_move", col, 24'h5E8F54);
        repeat (9) press(4'b0001);
        cur_c = 7;
        pixel(500, 0, col);  check("saturate_col7", col, 24'hFFFF00);
        pixel(440, 0, col);  check("col6_not_cursor", col, 24'h8CC783);

        // Flags
        pulse_new_game();
        pixel(80, 0, col);   check("newgame_cursor", col, 24'hFFFF00);
        pulse_flag();
        check("flag_on", bus.flag_count, 1);
        tile_px(0, 0, col);  check("flag_colour", col, 24'hFF00FF);
        pulse_flag();
        check("flag_off", bus.flag_count, 0);
        pulse_flag();
        pulse_reveal();
        check("reveal_flagged_ignored", bus.reveal_count, 0);
        bus.flag_sw = 1'b1; bus.reveal_sw = 1'b1; tick();
        bus.flag_sw = 1'b0; bus.reveal_sw = 1'b0; tick();
        check("both_edges_flag_dropped", bus.flag_count, 1);
        check("both_edges_no_reveal", bus.reveal_count, 0);

        // Lose on a mine
        pulse_new_game();
        check("newgame_flags_clear", bus.flag_count, 0);
        goto(5, 0);
        pulse_reveal();
        check("lost", bus.lost, 1);
        check("lost_count", bus.reveal_count, 1);
        tile_px(5, 3, col);  check("lost_other_mine", col, 24'hFF0000);
        tile_px(5, 0, col);  check("revealed_mine", col, 24'hFF0000);
        tile_px(0, 0, col);  check("lost_safe_unrevealed", col, 24'h8CC783);
        goto(0, 0);
        pulse_reveal();
        check("lost_reveal_ignored", bus.reveal_count, 1);
        pulse_flag();
        check("lost_flag_ignored", bus.flag_count, 0);

        // Zero-tile reveal at (0,0): cascade when flood is built, single tile otherwise
        pulse_new_game();
        check("newgame_clears_lost", bus.lost, 0);
        bus.reveal_sw = 1'b1;
        tick();
        bus.reveal_sw = 1'b0;
        n = 0;
        while (bus.busy && n < 2000) begin
            n++;
            tick();
        end
`ifdef BOARD_FLOOD_FILL_EN
        check("flood_busy_cycles", n, 128);
        check("flood_reveal_count", bus.reveal_count, 40);
        tile_px(3, 7, col);  check("flood_far_tile", col, 24'hFFFFFF);
`else
        check("noflood_busy", n, 0);
        check("noflood_reveal_count", bus.reveal_count, 1);
        tile_px(3, 7, col);  check("noflood_far_tile", col, 24'h8CC783);
`endif
        tile_px(0, 0, col);  check("zero_tile_white", col, 24'hFFFFFF);

        // Win: reveal every safe tile, keeping (6,0) for last
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (!mines[r * 8 + c] && !(r == 6 && c == 0)) begin
                    goto(r, c);
                    pulse_reveal();
                    n = 0;
                    while (bus.busy && n < 2000) begin
                        n++;
                        tick();
                    end
                    if (n >= 2000) timeouts++;
                end
            end
        end
        check("sweep_bounded", timeouts, 0);
        check("pre_win_count", bus.reveal_count, 53);
        check("pre_win_won", bus.won, 0);
        goto(6, 0);
        bus.reveal_sw = 1'b1;
        tick();
        check("won_next_cycle", bus.won, 1);
        check("win_count", bus.reveal_count, 54);
        check("win_not_lost", bus.lost, 0);
        bus.reveal_sw = 1'b0;
        tick();

        pulse_new_game();
        check("ng_reveal_count", bus.reveal_count, 0);
        check("ng_flag_count", bus.flag_count, 0);
        check("ng_busy", bus.busy, 0);
        check("ng_lost", bus.lost, 0);
        check("ng_won", bus.won, 0);
        pixel(80, 0, col);   check("ng_cursor", col, 24'hFFFF00);
        tile_px(1, 1, col);  check("ng_unrevealed", col, 24'h8CC783);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
